// File: rtl/wts_bus_pkg.sv
// Shared definitions for the wave table sound cartridge bus initiator:
// FSM state encoding, fixed response codes and bus widths.
`timescale 1ns/1ps
package wts_bus_pkg;

    localparam int WTS_ADR_W = 16;
    localparam int WTS_DAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } wts_state_e;

    localparam logic [WTS_DAT_W-1:0] WTS_RSP_WRITE   = 8'h00;
    localparam logic [WTS_DAT_W-1:0] WTS_RSP_TIMEOUT = 8'hFF;

endpackage

// File: rtl/wts_bus_initiator.sv
// Bus master for the OCM req/ack slot bus. Accepts one byte read/write
// command at a time, holds req until ack (or timeout), returns a single
// response pulse and then enforces a minimum low time on req.
`timescale 1ns/1ps
module wts_bus_initiator
    import wts_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic                 clk21m,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_wrt,
    input  logic [WTS_ADR_W-1:0] cmd_adr,
    input  logic [WTS_DAT_W-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [WTS_DAT_W-1:0] rsp_data,
    output logic                 rsp_timeout,
    output logic                 req,
    input  logic                 ack,
    output logic                 wrt,
    output logic [WTS_ADR_W-1:0] adr,
    output logic [WTS_DAT_W-1:0] dbo,
    input  logic [WTS_DAT_W-1:0] dbi
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(IDLE_GAP);

    wts_state_e state;
    wts_state_e state_nxt;
    logic [7:0] timer;
    logic [3:0] gap_cnt;
    logic       accept;
    logic       ack_hit;
    logic       timeout_hit;

    // Transaction events; ack takes priority over a coinciding timeout
    assign accept      = (state == ST_IDLE) && cmd_valid;
    assign ack_hit     = (state == ST_REQ) && ack;
    assign timeout_hit = (state == ST_REQ) && !ack && (timer == TIMER_LAST);

    // State register
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> REQ -> GAP -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)                  state_nxt = ST_REQ;
            ST_REQ:  if (ack_hit || timeout_hit)  state_nxt = ST_GAP;
            ST_GAP:  if (gap_cnt == 4'd1)         state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: commands are only taken while idle
    always_comb begin
        cmd_ready = 1'b0;
        if (state == ST_IDLE) begin
            cmd_ready = 1'b1;
        end
    end

    // Registered bus/response outputs plus the request timer and gap counter
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            req         <= 1'b0;
            wrt         <= 1'b0;
            adr         <= '0;
            dbo         <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            timer       <= '0;
            gap_cnt     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wrt   <= cmd_wrt;
                        adr   <= cmd_adr;
                        dbo   <= cmd_data;
                        req   <= 1'b1;
                        timer <= '0;
                    end
                end
                ST_REQ: begin
                    if (ack_hit) begin
                        req         <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_data    <= wrt ? WTS_RSP_WRITE : dbi;
                        gap_cnt     <= GAP_LOAD;
                    end else if (timeout_hit) begin
                        req         <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_data    <= WTS_RSP_TIMEOUT;
                        gap_cnt     <= GAP_LOAD;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != 4'd1) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wts_bus_initiator.sv
// Self-checking bench for wts_bus_initiator: directed scenarios plus
// randomized transactions compared against a transaction-level model.
`timescale 1ns/1ps
module tb_wts_bus_initiator;

    localparam int TIMEOUT  = 255;
    localparam int IDLE_GAP = 2;
    localparam int NEVER    = 100000;

    logic        clk21m = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wrt;
    logic [15:0] cmd_adr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_timeout;
    logic        req;
    logic        ack;
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  dbo;
    logic [7:0]  dbi;

    int checks   = 0;
    int failures = 0;

    wts_bus_initiator #(.TIMEOUT(TIMEOUT), .IDLE_GAP(IDLE_GAP)) dut (
        .clk21m(clk21m), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wrt(cmd_wrt),
        .cmd_adr(cmd_adr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .req(req), .ack(ack), .wrt(wrt), .adr(adr), .dbo(dbo), .dbi(dbi)
    );

    always #23 clk21m = ~clk21m;

    // Transaction-level expectation: the slave answers after lat cycles of req,
    // unless that exceeds the timeout, in which case req lasts TIMEOUT cycles.
    function automatic void model(input logic w, input int lat, input logic [7:0] di,
                                  output int hi, output logic [7:0] data, output logic to);
        if (lat <= TIMEOUT) begin
            hi = lat; to = 1'b0; data = w ? 8'h00 : di;
        end else begin
            hi = TIMEOUT; to = 1'b1; data = 8'hFF;
        end
    endfunction

    // Issues one command and plays a slave that acks on the lat-th cycle of req.
    // Returns observations only; each test compares them itself.
    task automatic drive_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                             input int lat, input logic [7:0] di,
                             output int hi, output int rsps, output int rsp_pos,
                             output logic [7:0] rdata, output logic rto,
                             output int gap, output int unstable, output bit hung);
        int  guard;
        bit  accepted;
        hi = 0; rsps = 0; rsp_pos = -1; rdata = 8'hxx; rto = 1'bx;
        gap = 0; unstable = 0; hung = 0;
        @(negedge clk21m);
        cmd_valid = 1'b1; cmd_wrt = w; cmd_adr = a; cmd_data = d;
        accepted = 0; guard = 0;
        while (!accepted && guard < 50) begin
            accepted = cmd_ready;
            @(negedge clk21m);
            guard++;
        end
        cmd_valid = 1'b0;
        cmd_wrt = 1'($urandom); cmd_adr = 16'($urandom); cmd_data = 8'($urandom);
        if (!accepted) begin
            hung = 1;
            return;
        end
        guard = 0;
        while (req && guard < 400) begin
            hi++;
            if (wrt !== w || adr !== a || dbo !== d) unstable++;
            if (rsp_valid) rsps++;
            if (hi == lat) begin ack = 1'b1; dbi = di; end
            else begin ack = 1'b0; dbi = 8'($urandom); end
            @(negedge clk21m);
            guard++;
        end
        ack = 1'b0;
        if (req) hung = 1;
        guard = 0;
        while (!cmd_ready && guard < 40) begin
            if (rsp_valid) begin
                rsps++; rsp_pos = gap; rdata = rsp_data; rto = rsp_timeout;
            end
            gap++;
            @(negedge clk21m);
            guard++;
        end
        if (!cmd_ready) hung = 1;
        if (rsp_valid) rsps++;
    endtask

    task automatic test_reset;
        #5;
        checks++; if (req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req actual=%b required=0", req); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready actual=%b required=1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || rsp_data !== 8'h00)
            begin failures++; $display("[TB] FAIL reset_rsp actual=%b/%b/%h required=0/0/00", rsp_valid, rsp_timeout, rsp_data); end
        checks++; if (wrt !== 1'b0 || adr !== 16'h0000 || dbo !== 8'h00)
            begin failures++; $display("[TB] FAIL reset_bus actual=%b/%h/%h required=0/0000/00", wrt, adr, dbo); end
        @(negedge clk21m); @(negedge clk21m);
        reset = 1'b0;
        @(negedge clk21m);
        checks++; if (cmd_ready !== 1'b1 || req !== 1'b0)
            begin failures++; $display("[TB] FAIL post_reset actual=ready%b req%b required=ready1 req0", cmd_ready, req); end
    endtask

    // Runs one transaction and checks all of its observations against the model
    task automatic test_txn(input string name, input logic w, input logic [15:0] a,
                            input logic [7:0] d, input int lat, input logic [7:0] di);
        int hi, rsps, pos, gap, unstable, e_hi;
        bit hung;
        logic [7:0] rdata, e_data;
        logic rto, e_to;
        model(w, lat, di, e_hi, e_data, e_to);
        drive_txn(w, a, d, lat, di, hi, rsps, pos, rdata, rto, gap, unstable, hung);
        checks++; if (hung) begin failures++; $display("[TB] FAIL %s_bound actual=hung required=complete", name); end
        checks++; if (hi != e_hi) begin failures++; $display("[TB] FAIL %s_req_cycles actual=%0d required=%0d", name, hi, e_hi); end
        checks++; if (rsps != 1 || pos != 0)
            begin failures++; $display("[TB] FAIL %s_rsp_pulse actual=count%0d pos%0d required=count1 pos0", name, rsps, pos); end
        checks++; if (rdata !== e_data) begin failures++; $display("[TB] FAIL %s_rsp_data actual=%h required=%h", name, rdata, e_data); end
        checks++; if (rto !== e_to) begin failures++; $display("[TB] FAIL %s_rsp_timeout actual=%b required=%b", name, rto, e_to); end
        checks++; if (gap != IDLE_GAP) begin failures++; $display("[TB] FAIL %s_gap actual=%0d required=%0d", name, gap, IDLE_GAP); end
        checks++; if (unstable != 0) begin failures++; $display("[TB] FAIL %s_bus_stable actual=%0d required=0", name, unstable); end
        checks++; if (wrt !== w || adr !== a || dbo !== d || rsp_data !== e_data || rsp_timeout !== e_to)
            begin failures++; $display("[TB] FAIL %s_hold actual=%b/%h/%h/%h required=%b/%h/%h/%h", name, wrt, adr, dbo, rsp_data, w, a, d, e_data); end
    endtask

    task automatic test_write;
        test_txn("write", 1'b1, 16'h9800, 8'h5A, 2, 8'hC3);
    endtask

    task automatic test_read_latency;
        test_txn("read10", 1'b0, 16'h9880, 8'h00, 10, 8'h3C);
    endtask

    task automatic test_timeout;
        test_txn("timeout", 1'b0, 16'h9881, 8'h77, NEVER, 8'h00);
    endtask

    task automatic test_ack_at_timeout;
        test_txn("ack_at_limit", 1'b0, 16'h98F0, 8'h00, TIMEOUT, 8'hA5);
    endtask

    task automatic test_stray_ack;
        int bad = 0;
        ack = 1'b1; dbi = 8'h99;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk21m);
            if (rsp_valid || req) bad++;
        end
        ack = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL stray_ack actual=%0d required=0", bad); end
    endtask

    task automatic test_back_to_back;
        int seg = 0, low_run = 0, rsps = 0;
        int hi_run [2];
        logic [7:0] dbo_seen [2];
        logic prev_req = 1'b0;
        hi_run = '{0, 0};
        dbo_seen = '{8'h00, 8'h00};
        @(negedge clk21m);
        cmd_valid = 1'b1; cmd_wrt = 1'b1; cmd_adr = 16'h9801; cmd_data = 8'h11;
        for (int c = 0; c < 30; c++) begin
            if (req && seg < 2) begin
                hi_run[seg]++; dbo_seen[seg] = dbo;
                cmd_data = 8'h22;
            end else if (!req && prev_req) begin
                seg++;
            end
            if (!req && seg == 1) low_run++;
            if (seg == 2) cmd_valid = 1'b0;
            if (rsp_valid) rsps++;
            ack = req || !cmd_ready;
            prev_req = req;
            @(negedge clk21m);
        end
        ack = 1'b0; cmd_valid = 1'b0;
        checks++; if (rsps != 2) begin failures++; $display("[TB] FAIL b2b_rsp_count actual=%0d required=2", rsps); end
        checks++; if (low_run != IDLE_GAP + 1) begin failures++; $display("[TB] FAIL b2b_low_cycles actual=%0d required=%0d", low_run, IDLE_GAP + 1); end
        checks++; if (hi_run[0] != 1 || hi_run[1] != 1)
            begin failures++; $display("[TB] FAIL b2b_req_cycles actual=%0d/%0d required=1/1", hi_run[0], hi_run[1]); end
        checks++; if (dbo_seen[0] !== 8'h11 || dbo_seen[1] !== 8'h22)
            begin failures++; $display("[TB] FAIL b2b_dbo actual=%h/%h required=11/22", dbo_seen[0], dbo_seen[1]); end
    endtask

    task automatic test_reset_mid_req;
        int bad = 0;
        @(negedge clk21m);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready actual=%b required=1", cmd_ready); end
        cmd_valid = 1'b1; cmd_wrt = 1'b0; cmd_adr = 16'h9882; cmd_data = 8'h00;
        @(negedge clk21m);
        cmd_valid = 1'b0;
        @(negedge clk21m); @(negedge clk21m);
        checks++; if (req !== 1'b1) begin failures++; $display("[TB] FAIL midrst_req_before actual=%b required=1", req); end
        reset = 1'b1;
        #1;
        checks++; if (req !== 1'b0 || rsp_valid !== 1'b0)
            begin failures++; $display("[TB] FAIL midrst_async actual=req%b rsp%b required=req0 rsp0", req, rsp_valid); end
        @(negedge clk21m); @(negedge clk21m);
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1 || adr !== 16'h0000)
            begin failures++; $display("[TB] FAIL midrst_release actual=ready%b adr%h required=ready1 adr0000", cmd_ready, adr); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk21m);
            if (rsp_valid || req) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL midrst_quiet actual=%0d required=0", bad); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 10; n++) begin
            logic        w;
            logic [15:0] a;
            logic [7:0]  d, di;
            int          lat;
            w   = 1'($urandom);
            a   = 16'($urandom);
            d   = 8'($urandom);
            di  = 8'($urandom);
            lat = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, 14));
            test_txn($sformatf("rand%0d", n), w, a, d, lat, di);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_wrt = 1'b0; cmd_adr = '0;
        cmd_data = '0; ack = 1'b0; dbi = '0;
        test_reset();
        test_write();
        test_read_latency();
        test_timeout();
        test_ack_at_timeout();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
